sound_scheduler: RTL and testbench

//  Arbitrates the six one-bit audio request lines from the sound request decoder onto the single tone/playback

---
 rtl/sound_scheduler.sv | 120 ++++++++++++
 tb/tb_sound_scheduler.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/sound_scheduler.sv
// rtl/sound_scheduler.sv - priority scheduler of six audio requests onto one tone path
// Optional SOUND_PREEMPT_EN: a higher-priority pending sound aborts the one playing.
module sound_scheduler #(
  parameter int CNT_W      = 24,
  parameter int DUR_KEY    = 2500000,
  parameter int DUR_COL    = 5000000,
  parameter int DUR_HOLE   = 12500000,
  parameter int GAP_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       keyXAudioRequest,
  input  logic       keyYAudioRequest,
  input  logic       keyEnterAudioRequest,
  input  logic       borderColAudioRequest,
  input  logic       ballToBallColAudioRequest,
  input  logic       holeColAudioRequest,
  output logic       soundEnable,
  output logic [2:0] soundId,
  output logic [5:0] pendingMask,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_GAP = 2'd2} state_t;

  localparam bit             HAS_GAP  = (GAP_CYCLES > 0);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t           r_state;
  state_t           w_next;
  logic [5:0]       w_req;
  logic [5:0]       r_req_q;
  logic [5:0]       w_rise;
  logic [5:0]       w_clr;
  logic [5:0]       r_pending;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_sound_id;
  logic [2:0]       w_hi_id;
  logic             w_any;
  logic             w_grant;
  logic             w_preempt;
  logic             w_cnt_zero;

  function automatic logic [CNT_W-1:0] dur_load(input logic [2:0] id);
    if (id == 3'd5)      return CNT_W'(DUR_HOLE - 1);
    else if (id >= 3'd3) return CNT_W'(DUR_COL - 1);
    else                 return CNT_W'(DUR_KEY - 1);
  endfunction

  assign w_req = {holeColAudioRequest, ballToBallColAudioRequest, borderColAudioRequest,
                  keyEnterAudioRequest, keyYAudioRequest, keyXAudioRequest};
  assign w_rise     = w_req & ~r_req_q;
  assign w_any      = |r_pending;
  assign w_cnt_zero = (r_cnt == '0);

  // Highest set bit wins: id 5 has top priority.
  always_comb begin
    w_hi_id = '0;
    for (int i = 0; i < 6; i++) begin
      if (r_pending[i]) w_hi_id = 3'(i);
    end
  end

`ifdef SOUND_PREEMPT_EN
  assign w_preempt = (r_state == S_PLAY) && w_any && (w_hi_id > r_sound_id);
`else
  assign w_preempt = 1'b0;
`endif

  assign w_grant = ((r_state == S_IDLE) && w_any) || w_preempt;
  assign w_clr   = w_grant ? (6'b000001 << w_hi_id) : 6'b000000;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_any) w_next = S_PLAY;
      S_PLAY: begin
        if (w_preempt)       w_next = S_PLAY;
        else if (w_cnt_zero) w_next = HAS_GAP ? S_GAP : S_IDLE;
      end
      S_GAP:  if (w_cnt_zero) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    soundEnable = (r_state == S_PLAY);
    busy        = (r_state != S_IDLE);
  end

  // A new rise in the same cycle as the grant clear keeps the bit set.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_req_q    <= '0;
      r_pending  <= '0;
      r_cnt      <= '0;
      r_sound_id <= '0;
    end else begin
      r_req_q   <= w_req;
      r_pending <= (r_pending & ~w_clr) | w_rise;
      if (w_grant) begin
        r_sound_id <= w_hi_id;
        r_cnt      <= dur_load(w_hi_id);
      end else if ((r_state == S_PLAY) && w_cnt_zero) begin
        r_cnt <= GAP_LOAD;
      end else if ((r_state != S_IDLE) && !w_cnt_zero) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign soundId     = r_sound_id;
  assign pendingMask = r_pending;

endmodule

// File: tb/tb_sound_scheduler.sv
// tb/tb_sound_scheduler.sv - directed bench for sound_scheduler
// Status word checked each cycle: {soundEnable, soundId, pendingMask, busy}.
module tb_sound_scheduler;

  logic       clk = 1'b0;
  logic       resetN;
  logic [5:0] req;
  logic       soundEnable;
  logic [2:0] soundId;
  logic [5:0] pendingMask;
  logic       busy;
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  sound_scheduler #(
    .CNT_W(8), .DUR_KEY(4), .DUR_COL(6), .DUR_HOLE(8), .GAP_CYCLES(2)
  ) dut (
    .clk                      (clk),
    .resetN                   (resetN),
    .keyXAudioRequest         (req[0]),
    .keyYAudioRequest         (req[1]),
    .keyEnterAudioRequest     (req[2]),
    .borderColAudioRequest    (req[3]),
    .ballToBallColAudioRequest(req[4]),
    .holeColAudioRequest      (req[5]),
    .soundEnable              (soundEnable),
    .soundId                  (soundId),
    .pendingMask              (pendingMask),
    .busy                     (busy)
  );

  task automatic chk(input string tag, input bit en, input logic [2:0] id,
                     input logic [5:0] pm, input bit bz);
    logic [10:0] obs;
    logic [10:0] exp;
    obs = {soundEnable, soundId, pendingMask, busy};
    exp = {en, id, pm, bz};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s at %0t: observed en=%b id=%0d pm=%b busy=%b, expected en=%b id=%0d pm=%b busy=%b",
             tag, $time, obs[10], obs[9:7], obs[6:1], obs[0], en, id, pm, bz);
    end
  endtask

  // Advance n clock edges, checking the status after each one.
  task automatic run(input string tag, input int n, input bit en, input logic [2:0] id,
                     input logic [5:0] pm, input bit bz);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk(tag, en, id, pm, bz);
    end
  endtask

  initial begin
    resetN = 1'b0;
    req    = 6'b0;
    @(negedge clk);
    chk("reset_in", 0, 0, 6'b0, 0);
    @(negedge clk);
    resetN = 1'b1;
    run("reset_idle", 20, 0, 0, 6'b0, 0);

    // Single keyX held for 30 cycles plays exactly once.
    req = 6'b000001;
    run("keyx_latch", 1, 0, 0, 6'b000001, 0);
    run("keyx_play",  4, 1, 0, 6'b0, 1);
    run("keyx_gap",   2, 0, 0, 6'b0, 1);
    run("keyx_idle", 23, 0, 0, 6'b0, 0);
    req = 6'b0;
    run("keyx_drop",  1, 0, 0, 6'b0, 0);

    // keyX, border, hole together: served 5, 3, 0.
    req = 6'b101001;
    run("multi_latch", 1, 0, 0, 6'b101001, 0);
    run("multi_p5",    8, 1, 5, 6'b001001, 1);
    run("multi_g5",    2, 0, 5, 6'b001001, 1);
    run("multi_i5",    1, 0, 5, 6'b001001, 0);
    run("multi_p3",    6, 1, 3, 6'b000001, 1);
    run("multi_g3",    2, 0, 3, 6'b000001, 1);
    run("multi_i3",    1, 0, 3, 6'b000001, 0);
    run("multi_p0",    4, 1, 0, 6'b0, 1);
    run("multi_g0",    2, 0, 0, 6'b0, 1);
    run("multi_i0",    1, 0, 0, 6'b0, 0);
    req = 6'b0;
    run("multi_drop",  1, 0, 0, 6'b0, 0);

    // Border re-pulsed mid-play, then pulsed again exactly on the clearing edge.
    req = 6'b001000;
    run("rep_latch", 1, 0, 0, 6'b001000, 0);
    req = 6'b0;
    run("rep_p1a",   2, 1, 3, 6'b0, 1);
    req = 6'b001000;
    run("rep_p1b",   1, 1, 3, 6'b001000, 1);
    req = 6'b0;
    run("rep_p1c",   3, 1, 3, 6'b001000, 1);
    run("rep_g1",    2, 0, 3, 6'b001000, 1);
    run("rep_i1",    1, 0, 3, 6'b001000, 0);
    req = 6'b001000;
    run("setwins",   1, 1, 3, 6'b001000, 1);
    req = 6'b0;
    run("rep_p2",    5, 1, 3, 6'b001000, 1);
    run("rep_g2",    2, 0, 3, 6'b001000, 1);
    run("rep_i2",    1, 0, 3, 6'b001000, 0);
    run("rep_p3",    6, 1, 3, 6'b0, 1);
    run("rep_g3",    2, 0, 3, 6'b0, 1);
    run("rep_i3",    3, 0, 3, 6'b0, 0);

    // Hole arrives during a keyX play.
    req = 6'b000001;
    run("pre_latch", 1, 0, 3, 6'b000001, 0);
    run("pre_p0a",   1, 1, 0, 6'b0, 1);
    req = 6'b100000;
    run("pre_p0b",   1, 1, 0, 6'b100000, 1);
`ifdef SOUND_PREEMPT_EN
    run("pre_p5",    8, 1, 5, 6'b0, 1);
`else
    run("pre_p0c",   2, 1, 0, 6'b100000, 1);
    run("pre_g0",    2, 0, 0, 6'b100000, 1);
    run("pre_i0",    1, 0, 0, 6'b100000, 0);
    run("pre_p5",    8, 1, 5, 6'b0, 1);
`endif
    run("pre_g5",    2, 0, 5, 6'b0, 1);
    run("pre_i5",    4, 0, 5, 6'b0, 0);
    req = 6'b0;
    run("pre_drop",  1, 0, 5, 6'b0, 0);

    // Asynchronous reset mid-play discards the pending keyX.
    req = 6'b100000;
    run("rst_latch", 1, 0, 5, 6'b100000, 0);
    run("rst_play",  1, 1, 5, 6'b0, 1);
    req = 6'b100001;
    run("rst_pend",  1, 1, 5, 6'b000001, 1);
    resetN = 1'b0;
    #1;
    chk("rst_async", 0, 0, 6'b0, 0);
    req = 6'b0;
    run("rst_hold",  2, 0, 0, 6'b0, 0);
    resetN = 1'b1;
    run("rst_after", 5, 0, 0, 6'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
